// File: rtl/button_debounce_pulse_if.sv
// Button conditioning bundle: raw button in, debounced level/strobe/counter/state out.
// master = debouncer side, slave = button source and downstream consumer.
interface button_debounce_pulse_if;
    logic       btn_raw;
    logic       btn_level;
    logic       btn_pulse;
    logic [7:0] press_count;
    logic [1:0] state;

    modport master (
        input  btn_raw,
        output btn_level,
        output btn_pulse,
        output press_count,
        output state
    );

    modport slave (
        output btn_raw,
        input  btn_level,
        input  btn_pulse,
        input  press_count,
        input  state
    );
endinterface

// File: rtl/button_debounce_pulse.sv
// Button debouncer: 2-flop synchronizer, press/release qualification FSM,
// one-cycle press strobe and wrapping press counter.
// Optional macro AUTO_REPEAT_EN adds periodic strobes while the button is held.
module button_debounce_pulse #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_CYCLES   = 25000000
) (
    input  logic                  clk,
    input  logic                  Reset,
    button_debounce_pulse_if.master bus
);

    localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_param
        $error("button_debounce_pulse: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PWAIT = 2'd1,
        S_HELD  = 2'd2,
        S_RWAIT = 2'd3
    } state_t;

    logic          sync1_q;
    logic          sync1_d;
    logic          btn_sync_q;
    logic          btn_sync_d;
    state_t        state_q;
    state_t        state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_q;
    logic          level_d;
    logic          pulse_q;
    logic          pulse_d;
    logic [7:0]    count_q;
    logic [7:0]    count_d;

`ifdef AUTO_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 2) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] RCNT_LAST = RW'(REPEAT_CYCLES - 1);

    logic [RW-1:0] rcnt_q;
    logic [RW-1:0] rcnt_d;
`endif

    // Next-state logic: synchronizer shift and debounce qualification.
    always_comb begin
        sync1_d    = bus.btn_raw;
        btn_sync_d = sync1_q;
        state_d    = state_q;
        cnt_d      = cnt_q;
        level_d    = level_q;
        pulse_d    = 1'b0;
        count_d    = count_q;
`ifdef AUTO_REPEAT_EN
        rcnt_d     = '0;
`endif
        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (btn_sync_q) begin
                    state_d = S_PWAIT;
                end
            end
            S_PWAIT: begin
                if (!btn_sync_q) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    pulse_d = 1'b1;
                    count_d = count_q + 8'd1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_HELD: begin
                cnt_d = '0;
                if (!btn_sync_q) begin
                    state_d = S_RWAIT;
`ifdef AUTO_REPEAT_EN
                end else if (rcnt_q == RCNT_LAST) begin
                    pulse_d = 1'b1;
                    count_d = count_q + 8'd1;
                    rcnt_d  = '0;
                end else begin
                    rcnt_d = rcnt_q + 1'b1;
`endif
                end
            end
            S_RWAIT: begin
                if (btn_sync_q) begin
                    state_d = S_HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // State and output registers; reset wins over any pending event.
    always_ff @(posedge clk) begin
        if (Reset) begin
            sync1_q    <= 1'b0;
            btn_sync_q <= 1'b0;
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            level_q    <= 1'b0;
            pulse_q    <= 1'b0;
            count_q    <= 8'd0;
`ifdef AUTO_REPEAT_EN
            rcnt_q     <= '0;
`endif
        end else begin
            sync1_q    <= sync1_d;
            btn_sync_q <= btn_sync_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_q    <= level_d;
            pulse_q    <= pulse_d;
            count_q    <= count_d;
`ifdef AUTO_REPEAT_EN
            rcnt_q     <= rcnt_d;
`endif
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_pulse   = pulse_q;
    assign bus.press_count = count_q;
    assign bus.state       = state_q;

endmodule
